// File: rtl/des_key_schedule.sv
// des_key_schedule
//   DES (FIPS 46-3) round-subkey generator. A 64-bit key is captured through
//   PC-1 into the 28-bit C and D halves, then sixteen 48-bit subkeys are
//   streamed out through PC-2 with a valid/ready handshake, in encrypt order
//   (K1..K16) or decrypt order (K16..K1).
//
// Ports
//   clk            : clock, rising edge active
//   rst            : asynchronous active-high reset
//   key_i          : 64-bit DES key, bit 1 = MSB, parity bits 8,16,...,64 ignored
//   dir_i          : 0 = encrypt order K1..K16, 1 = decrypt order K16..K1
//   start_i        : request a new schedule (taken only while ready_o = 1)
//   ready_o        : idle, able to accept start_i
//   subkey_o       : current round subkey, bit 1 = MSB
//   subkey_valid_o : subkey_o is valid
//   subkey_ready_i : consumer accepts subkey_o
//   round_o        : absolute key number of subkey_o, 0..15 = K1..K16
//   last_o         : subkey_o is the 16th subkey emitted
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key_i,
    input  logic        dir_i,
    input  logic        start_i,
    output logic        ready_o,
    output logic [1:48] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        last_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Rounds whose shift is a single position (indices 0, 1, 8, 15); all
    // other rounds shift by two.
    localparam logic [15:0] ONE_SHIFT_MASK = 16'h8103;

    // ------------------------------------------------------------------
    // Permutations
    // ------------------------------------------------------------------
    function automatic logic [1:56] pc1(input logic [1:64] k);
        return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],
                k[58], k[50], k[42], k[34], k[26], k[18], k[10], k[2],
                k[59], k[51], k[43], k[35], k[27], k[19], k[11], k[3],
                k[60], k[52], k[44], k[36],
                k[63], k[55], k[47], k[39], k[31], k[23], k[15], k[7],
                k[62], k[54], k[46], k[38], k[30], k[22], k[14], k[6],
                k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],
                k[28], k[20], k[12], k[4]};
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

    // Bit 1 is the MSB, so a left rotation moves bit 1 to the tail.
    function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:28] c_q, c_d;
    logic [1:28] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;

    logic [1:56] cap_cd;
    logic [3:0]  shift_idx;
    logic        shift_two;
    logic        handshake;

    // Parity bits play no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                             key_i[40], key_i[48], key_i[56], key_i[64]};

    assign cap_cd    = pc1(key_i);
    assign handshake = (state_q == RUN) && subkey_ready_i;

    // Encrypt advances to the next round's shift; decrypt undoes the shift
    // of the round currently presented (round_o = 15 - cnt_q).
    assign shift_idx = dir_q ? (4'd15 - cnt_q) : (cnt_q + 4'd1);
    assign shift_two = ~ONE_SHIFT_MASK[shift_idx];

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Decrypt starts from the unrotated halves: the total
                    // shift over 16 rounds is 28, so C0/D0 already give K16.
                    if (dir_i) begin
                        c_d = cap_cd[1:28];
                        d_d = cap_cd[29:56];
                    end else begin
                        c_d = rotl(cap_cd[1:28], 1'b0);
                        d_d = rotl(cap_cd[29:56], 1'b0);
                    end
                    dir_d   = dir_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (dir_q) begin
                            c_d = rotr(c_q, shift_two);
                            d_d = rotr(d_q, shift_two);
                        end else begin
                            c_d = rotl(c_q, shift_two);
                            d_d = rotl(d_q, shift_two);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state only
    // ------------------------------------------------------------------
    assign ready_o        = (state_q == IDLE);
    assign subkey_valid_o = (state_q == RUN);
    assign subkey_o       = pc2({c_q, d_q});
    assign round_o        = dir_q ? (4'd15 - cnt_q) : cnt_q;
    assign last_o         = (cnt_q == 4'd15);

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by FIPS 46-3.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_i, input, [1:64]: 64-bit DES key, bit 1 = MSB, parity bits 8,16,...,64 ignored.
REQ-005 The block SHALL have port dir_i, input, 1 bit: 0 = encrypt order K1..K16, 1 = decrypt order K16..K1.
REQ-006 The block SHALL have port start_i, input, 1 bit: request a new schedule, sampled with key_i and dir_i.
REQ-007 The block SHALL have port ready_o, output, 1 bit: idle and able to accept start_i.
REQ-008 The block SHALL have port subkey_o, output, [1:48]: current round subkey, bit 1 = MSB.
REQ-009 The block SHALL have port subkey_valid_o, output, 1 bit: subkey_o is valid.
REQ-010 The block SHALL have port subkey_ready_i, input, 1 bit: consumer accepts subkey_o.
REQ-011 The block SHALL have port round_o, output, [3:0]: index of the presented subkey, 0..15 = K1..K16 (absolute key number, not emission order).
REQ-012 The block SHALL have port last_o, output, 1 bit: the presented subkey is the 16th emitted.

Function
REQ-013 The block SHALL use two states. IDLE: ready_o=1, subkey_valid_o=0. RUN: ready_o=0, subkey_valid_o=1.
REQ-014 In IDLE, when start_i=1 at a clock edge, the block SHALL capture key_i through PC-1 into C (28 bits) and D (28 bits), latch dir_i, and enter RUN.
REQ-015 The first subkey SHALL be presented in the cycle after start is accepted (latency 1).
REQ-016 subkey_o SHALL be PC-2 applied to the registered C and D values; it SHALL be registered-state derived and SHALL NOT combinationally depend on inputs.
REQ-017 Encrypt on capture SHALL left-rotate C and D once, so the first subkey is K1.
REQ-018 Encrypt on each subsequent handshake SHALL left-rotate C and D by the shift amount of the next round, in the sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 Decrypt on capture SHALL apply no rotation, so the first subkey is K16 (total shift 28 equals identity).
REQ-020 Decrypt on each subsequent handshake SHALL right-rotate C and D by the emission sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 A handshake SHALL occur when subkey_valid_o=1 and subkey_ready_i=1 at a clock edge.
REQ-022 While subkey_ready_i=0, subkey_o, round_o, last_o and C/D SHALL hold stable.
REQ-023 The emission counter SHALL be 4 bits, 0..15.
REQ-024 round_o SHALL equal the counter in encrypt mode and 15 minus the counter in decrypt mode.
REQ-025 last_o SHALL be 1 exactly when the counter equals 15.
REQ-026 A handshake with last_o=1 SHALL return the block to IDLE, with ready_o=1 in the next cycle.
REQ-027 No 17th subkey SHALL be emitted, and the counter SHALL NOT wrap.
REQ-028 start_i SHALL be ignored while in RUN; an in-progress schedule SHALL NOT be restarted or corrupted.
REQ-029 A start_i asserted in the same cycle as the final handshake SHALL be ignored, because ready_o=0 in that cycle.
REQ-030 Changes on key_i or dir_i after capture SHALL NOT affect the running schedule.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, ready_o=1, subkey_valid_o=0, subkey_o=0, round_o=0, last_o=0, C=0, D=0, counter=0.
REQ-032 Reset asserted mid-RUN SHALL abort the schedule immediately.
REQ-033 The first start_i SHALL be accepted at the first clock edge after rst deasserts.

Verification
REQ-034 Encrypt: key_i=0x133457799BBCDFF1, dir_i=0, start pulse, subkey_ready_i=1 -> K1=0x1B02EFFC7072 one cycle later, 16 consecutive valid cycles, final subkey 0xCB3D8B0E17F5 with last_o=1, round_o=15.
REQ-035 Decrypt: same key, dir_i=1 -> first subkey 0xCB3D8B0E17F5 with round_o=15, last 0x1B02EFFC7072 with round_o=0 and last_o=1; the sequence is the exact reverse of REQ-034.
REQ-036 Backpressure: random subkey_ready_i with 50% low -> outputs stable while stalled, same 16-value sequence as REQ-034, no drops or duplicates.
REQ-037 Start in RUN: pulse start_i with a different key during round 5 -> ignored, sequence unchanged, ready_o=0 until after the final handshake.
REQ-038 Reset mid-operation: assert rst after the 7th subkey -> subkey_valid_o=0 and ready_o=1 immediately without a clock edge; a new start then yields a correct K1.
REQ-039 Parity independence: key 0x133457799BBCDFF1 with all parity bits flipped (XOR 0x0101010101010101) -> subkeys identical to REQ-034.
